// File: rtl/barrett_arbiter_if.sv
// Request/response bundle for barrett_arbiter: NREQ valid/ready operand ports
// plus one tagged, back-pressured result port.
interface barrett_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [15:0]        rsp_data;
    logic [ID_W-1:0]    rsp_id;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/barrett_arbiter.sv
// Round-robin arbiter feeding one shared Barrett reducer (mod 3329) through a 2-stage pipe.
// Define BARRETT_ARB_STATS_EN to add saturating grant_cnt / stall_cnt outputs.
module barrett_arbiter #(
    parameter int NREQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    barrett_arbiter_if.slave   bus
`ifdef BARRETT_ARB_STATS_EN
    ,
    output logic [15:0]        grant_cnt,
    output logic [15:0]        stall_cnt
`endif
);
    localparam int ID_W = $clog2(NREQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);
    localparam logic [32:0] BARRETT_M = 33'((65'd1 << 44) / 65'd3329);

    // Quotient estimate is at most one short for 32-bit inputs, so one correction suffices.
    function automatic logic [15:0] barrett_reduction(input logic [31:0] x);
        logic [20:0] q;
        logic [31:0] r;
        q = 21'(({33'b0, x} * {32'b0, BARRETT_M}) >> 44);
        r = x - 32'(q) * 32'd3329;
        if (r >= 32'd3329) r = r - 32'd3329;
        return r[15:0];
    endfunction

    logic [ID_W-1:0] rr_ptr;
    logic            s1_valid;
    logic [31:0]     s1_data;
    logic [ID_W-1:0] s1_id;
    logic            rsp_valid;
    logic [15:0]     rsp_data;
    logic [ID_W-1:0] rsp_id;

    logic            adv1, adv2, found, accept;
    logic [ID_W-1:0] win;
    logic [31:0]     win_data;
    logic [NREQ-1:0] req_ready;

    assign adv2   = !rsp_valid || bus.rsp_ready;
    assign adv1   = !s1_valid || adv2;
    assign accept = found && adv1 && !rst;

    // First pass covers indices at/above the pointer, second pass the wrapped remainder.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && ID_W'(j) >= rr_ptr && bus.req_valid[j]) begin
                found = 1'b1;
                win   = ID_W'(j);
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && bus.req_valid[j]) begin
                found = 1'b1;
                win   = ID_W'(j);
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (ID_W'(j) == win) win_data = bus.req_data[32*j +: 32];
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            if (adv2) begin
                rsp_valid <= s1_valid;
                rsp_data  <= barrett_reduction(s1_data);
                rsp_id    <= s1_id;
            end
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= win_data;
                s1_id    <= win;
                rr_ptr   <= (win == LAST_ID) ? '0 : win + 1'b1;
            end else if (adv1) begin
                s1_valid <= 1'b0;
            end
        end
    end

`ifdef BARRETT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept && grant_cnt != '1) grant_cnt <= grant_cnt + 16'd1;
            if (rsp_valid && !bus.rsp_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_id    = rsp_id;
endmodule

// File: tb/tb_barrett_arbiter.sv
// Scoreboard bench for barrett_arbiter: accepts push expected results, a monitor pops them.
module tb_barrett_arbiter;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    barrett_arbiter_if #(.NREQ(NREQ)) bus ();
`ifdef BARRETT_ARB_STATS_EN
    logic [15:0] grant_cnt, stall_cnt;
`endif

    barrett_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef BARRETT_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    typedef struct { logic [31:0] d; logic [15:0] e; } op_t;
    typedef struct { logic [1:0] id; logic [15:0] e; int acc; } exp_t;

    op_t  rq[NREQ][$];
    exp_t sb[$];
    int   grants[$];
    int   gcyc[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   lat_check = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bit idle();
        bit r;
        r = (sb.size() == 0);
        for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    // Requester model: present the head of each queue, updated after every edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        #2;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = (rq[i].size() != 0);
            if (rq[i].size() != 0) bus.req_data[32*i +: 32] = rq[i][0].d;
            else bus.req_data[32*i +: 32] = '0;
        end
    end

    // Monitor: check responses first, then log this cycle's handshakes.
    initial forever begin
        op_t  o;
        exp_t x;
        @(negedge clk);
        check("req_ready_onehot",
              32'(($countones(bus.req_ready) <= 1) && ((bus.req_ready & ~bus.req_valid) == '0)), 32'd1);
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(bus.rsp_id), 32'hFFFF_FFFF);
            end else begin
                x = sb.pop_front();
                check("rsp_data", 32'(bus.rsp_data), 32'(x.e));
                check("rsp_id", 32'(bus.rsp_id), 32'(x.id));
                if (lat_check) check("latency", 32'(cyc - x.acc), 32'd2);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                o = rq[i].pop_front();
                sb.push_back('{id: 2'(i), e: o.e, acc: cyc});
                grants.push_back(i);
                gcyc.push_back(cyc);
            end
        end
    end

    task automatic wait_drain(input int max_cyc);
        int c;
        c = 0;
        while (!idle() && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        if (!idle()) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x;
        int          r;
        int          c;
`ifdef BARRETT_ARB_STATS_EN
        int          s0;
`endif
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;

        // Reset with every requester valid; then fairness stream of 3 ops each.
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NREQ; i++)
                rq[i].push_back('{32'(3329 * k + 10 * i + k), 16'(10 * i + k)});
        repeat (3) begin
            @(negedge clk);
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
            check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        end
        @(posedge clk);
        #1;
        grants.delete();
        gcyc.delete();
        rst = 1'b0;
        lat_check = 1'b1;
        wait_drain(100);
        check("fair_grant_count", 32'(grants.size()), 32'd12);
        for (int k = 0; k < grants.size(); k++) begin
            check("fair_grant_order", 32'(grants[k]), 32'(k % 4));
            if (k > 0) check("fair_grant_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd1);
        end

        // Single request and value corners.
        rq[2].push_back('{32'hFFFF_FFFF, 16'h0548});
        wait_drain(20);
        rq[1].push_back('{32'h0000_0D01, 16'h0000});
        rq[1].push_back('{32'h0000_0D00, 16'h0D00});
        rq[1].push_back('{32'h0000_1A02, 16'h0000});
        rq[1].push_back('{32'h0000_0000, 16'h0000});
        wait_drain(40);

        // Random operands under random response backpressure.
        lat_check = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            r = $urandom_range(0, NREQ - 1);
            x = $urandom;
            rq[r].push_back('{x, 16'(x % 32'd3329)});
        end
        c = 0;
        while (!idle() && c < 8000) begin
            @(posedge clk);
            #1;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            c++;
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_drain(50);

        // Backpressure with a full pipeline: 65536 mod 3329 = 2285.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < NREQ; i++)
                rq[i].push_back('{32'h0001_0000 + 32'(16 * i + k), 16'(2285 + 16 * i + k)});
        repeat (3) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
`ifdef BARRETT_ARB_STATS_EN
            if (k == 0) s0 = int'(stall_cnt);
`endif
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        check("bp_inflight", 32'(sb.size()), 32'd2);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
`ifdef BARRETT_ARB_STATS_EN
        check("bp_stall_delta", 32'(int'(stall_cnt) - s0), 32'd5);
`endif
        wait_drain(60);

        // Reset with two operands in flight from requester 1 (pointer ends at 2).
        bus.rsp_ready = 1'b0;
        rq[1].push_back('{32'd5, 16'd5});
        rq[1].push_back('{32'd6, 16'd6});
        c = 0;
        while (sb.size() != 2 && c < 10) begin
            @(negedge clk);
            c++;
        end
        check("mid_inflight", 32'(sb.size()), 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
`ifdef BARRETT_ARB_STATS_EN
            if (k == 0) begin
                check("mid_grant_cnt", 32'(grant_cnt), 32'd0);
                check("mid_stall_cnt", 32'(stall_cnt), 32'd0);
            end
`endif
        end
        @(posedge clk);
        #1;
        grants.delete();
        for (int i = 0; i < NREQ; i++) rq[i].push_back('{32'(3329 + i), 16'(i)});
        wait_drain(30);
        check("mid_grants", 32'(grants.size()), 32'd4);
        if (grants.size() > 0) check("mid_first_grant", 32'(grants[0]), 32'd0);
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
